// File: rtl/crc_stream_calculator.sv
// crc_stream_calculator: streaming bytewise CRC over a valid/ready packet stream with a held result port.
// Define CRC_CHECK_EN to add o_ok, flagging results equal to CHECKVAL.
module crc_stream_calculator #(
  parameter int DATAWIDTH = 32,
  parameter int CRCWIDTH = 16,
  parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 16'h8005,
  parameter logic [CRCWIDTH-1:0] INIT = 16'h0000,
  parameter logic [CRCWIDTH-1:0] XOROUT = 16'h0000,
  parameter bit REFIN = 1,
  parameter bit REFOUT = 1,
  parameter int EMPTYWIDTH = (DATAWIDTH / 8 > 1) ? $clog2(DATAWIDTH / 8) : 1,
  parameter logic [CRCWIDTH-1:0] CHECKVAL = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATAWIDTH-1:0]  i_dat,
  input  logic                  i_val,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic [EMPTYWIDTH-1:0] i_empty,
  output logic                  i_rdy,
  output logic [CRCWIDTH-1:0]   o_crc,
  output logic                  o_val,
`ifdef CRC_CHECK_EN
  output logic                  o_ok,
`endif
  input  logic                  o_rdy
);
  localparam int NB = DATAWIDTH / 8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_d;
  logic [CRCWIDTH-1:0] crc_q, nxt, post;
  logic [CRCWIDTH-1:0] taps [0:NB];
  logic take;
  int used_n;
  function automatic logic [7:0] refl8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction
  function automatic logic [CRCWIDTH-1:0] refl(input logic [CRCWIDTH-1:0] v);
    logic [CRCWIDTH-1:0] r;
    for (int i = 0; i < CRCWIDTH; i++) r[i] = v[CRCWIDTH-1-i];
    return r;
  endfunction
  function automatic logic [CRCWIDTH-1:0] crc_byte(input logic [CRCWIDTH-1:0] c, input logic [7:0] b);
    logic [CRCWIDTH-1:0] r;
    r = c;
    for (int k = 7; k >= 0; k--) r = (r[CRCWIDTH-1] ^ b[k]) ? ((r << 1) ^ POLYNOMIAL) : (r << 1);
    return r;
  endfunction
  assign take = i_val & i_rdy & (i_sop | (state == BUSY));
  // Byte chain: taps[n] is the CRC after the first n bytes; the eop word selects its tap.
  always_comb begin
    taps[0] = i_sop ? INIT : crc_q;
    for (int i = 0; i < NB; i++)
      taps[i+1] = crc_byte(taps[i], REFIN ? refl8(i_dat[DATAWIDTH-1-8*i -: 8]) : i_dat[DATAWIDTH-1-8*i -: 8]);
    used_n = i_eop ? NB - ((int'(i_empty) > NB - 1) ? NB - 1 : int'(i_empty)) : NB;
    nxt = taps[NB];
    for (int i = 1; i < NB; i++) nxt = (i == used_n) ? taps[i] : nxt;
    post = (REFOUT ? refl(nxt) : nxt) ^ XOROUT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = take ? (i_eop ? DONE : BUSY) : ((state == DONE) && o_rdy) ? IDLE : state;
  always_comb begin
    o_val = state == DONE;
    i_rdy = (state != DONE) | o_rdy;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      crc_q <= INIT;
      o_crc <= '0;
    end else if (take) begin
      crc_q <= nxt;
      if (i_eop) o_crc <= post;
    end
`ifdef CRC_CHECK_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) o_ok <= 1'b0;
    else if (take && i_eop) o_ok <= post == CHECKVAL;
`else
  logic unused_checkval;
  assign unused_checkval = ^CHECKVAL;
`endif
endmodule

// File: tb/tb_crc_stream_calculator.sv
// tb_crc_stream_calculator: scoreboard bench over ARC, non-reflected and CRC-32 instances sharing one stream.
module tb_crc_stream_calculator;
  typedef logic [7:0] bq_t[$];
  logic clk, reset, i_val, i_sop, i_eop, o_rdy;
  logic [31:0] i_dat;
  logic [1:0] i_empty;
  logic i_rdy, o_val_a, o_val_b, o_val_c, i_rdy_b, i_rdy_c;
  logic [15:0] o_crc_a, o_crc_b;
  logic [31:0] o_crc_c;
  logic [15:0] qa[$], qb[$];
  logic [31:0] qc[$];
  int vec = 0, errs = 0;
`ifdef CRC_CHECK_EN
  logic o_ok_a, o_ok_b, o_ok_c;
`endif
  crc_stream_calculator dut_a (
    .clk(clk), .reset(reset), .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop),
    .i_empty(i_empty), .i_rdy(i_rdy), .o_crc(o_crc_a), .o_val(o_val_a),
`ifdef CRC_CHECK_EN
    .o_ok(o_ok_a),
`endif
    .o_rdy(o_rdy));
  crc_stream_calculator #(.REFIN(0), .REFOUT(0)) dut_b (
    .clk(clk), .reset(reset), .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop),
    .i_empty(i_empty), .i_rdy(i_rdy_b), .o_crc(o_crc_b), .o_val(o_val_b),
`ifdef CRC_CHECK_EN
    .o_ok(o_ok_b),
`endif
    .o_rdy(o_rdy));
  crc_stream_calculator #(.CRCWIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .XOROUT(32'hFFFFFFFF), .CHECKVAL(32'h0)) dut_c (
    .clk(clk), .reset(reset), .i_dat(i_dat), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop),
    .i_empty(i_empty), .i_rdy(i_rdy_c), .o_crc(o_crc_c), .o_val(o_val_c),
`ifdef CRC_CHECK_EN
    .o_ok(o_ok_c),
`endif
    .o_rdy(o_rdy));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] crc_arc(input bq_t b);
    logic [15:0] c = 16'h0000;
    foreach (b[i]) begin
      c ^= {8'h00, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction
  // Every accepted result on the ARC instance must match the head of its queue.
  always @(negedge clk) if (reset && o_val_a && o_rdy) begin
    check("result_expected_a", qa.size() != 0, 1);
    if (qa.size() != 0) begin
      logic [15:0] e;
      e = qa.pop_front();
      check("crc_a", o_crc_a, e);
`ifdef CRC_CHECK_EN
      check("ok_a", o_ok_a, e == 16'h0000);
`endif
    end
  end
  always @(negedge clk) if (reset && o_val_b && o_rdy && qb.size() != 0) check("crc_b", o_crc_b, qb.pop_front());
  always @(negedge clk) if (reset && o_val_c && o_rdy && qc.size() != 0) check("crc_c", o_crc_c, qc.pop_front());
  task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] m);
    int n;
    i_dat = d; i_sop = s; i_eop = e; i_empty = m; i_val = 1;
    n = 0;
    @(negedge clk);
    while (!i_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rdy_wait", n < 50, 1);
    @(posedge clk);
    #1 i_val = 0;
  endtask
  task automatic pkt(input bq_t b, input logic [15:0] ea);
    int nw;
    logic [31:0] d;
    nw = (b.size() + 3) / 4;
    qa.push_back(ea);
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int j = 0; j < 4; j++) if (4 * w + j < b.size()) d[31-8*j -: 8] = b[4*w+j];
      send(d, w == 0, w == nw - 1, (w == nw - 1) ? 2'(4 * nw - b.size()) : 2'd0);
    end
    check("latency_oval", o_val_a, 1);
  endtask
  initial begin
    bq_t s9, b11, r;
    logic [7:0] c;
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    reset = 0; i_val = 0; i_sop = 0; i_eop = 0; i_empty = 0; i_dat = 0; o_rdy = 1;
    @(negedge clk);
    check("rst_oval", o_val_a, 0);
    check("rst_ocrc_a", o_crc_a, 0);
    check("rst_ocrc_c", o_crc_c, 0);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 check("rst_irdy", i_rdy, 1);
    qb.push_back(16'hFEE8);
    qc.push_back(32'hCBF43926);
    pkt(s9, 16'hBB3D);
    @(posedge clk);
    #1 o_rdy = 0;
    pkt(s9, 16'hBB3D);
    r = '{8'h31, 8'h32, 8'h33, 8'h34};
    i_dat = 32'h31323334; i_sop = 1; i_eop = 1; i_empty = 0; i_val = 1;
    qa.push_back(crc_arc(r));
    repeat (5) begin
      @(negedge clk);
      check("bp_oval", o_val_a, 1);
      check("bp_hold_crc", o_crc_a, 16'hBB3D);
      check("bp_irdy", i_rdy, 0);
    end
    @(posedge clk);
    #1 o_rdy = 1;
    @(negedge clk);
    check("bp_release_irdy", i_rdy, 1);
    @(posedge clk);
    #1 i_val = 0;
    check("no_bubble_oval", o_val_a, 1);
    check("no_bubble_crc", o_crc_a, crc_arc(r));
    @(posedge clk);
    #1 send(32'h41424344, 0, 1, 0);
    check("idle_drop", o_val_a, 0);
    send(32'h78787878, 1, 0, 0);
    pkt(s9, 16'hBB3D);
    @(posedge clk);
    #1 send(32'h31323334, 1, 0, 0);
    reset = 0;
    #1 check("rst_mid_oval", o_val_a, 0);
    #2 reset = 1;
    @(posedge clk);
    #1 o_rdy = 0;
    send(32'h39393939, 1, 1, 0);
    check("done_oval", o_val_a, 1);
    reset = 0;
    #1 check("rst_done_oval", o_val_a, 0);
    check("rst_done_crc", o_crc_a, 0);
    #2 reset = 1;
    o_rdy = 1;
    @(posedge clk);
    #1 pkt(s9, 16'hBB3D);
    b11 = s9;
    b11.push_back(8'h3D);
    b11.push_back(8'hBB);
    pkt(b11, 16'h0000);
    b11[4] = b11[4] ^ 8'h10;
    pkt(b11, crc_arc(b11));
    for (int p = 0; p < 5; p++) begin
      r = {};
      for (int k = 0; k < int'($urandom_range(1, 13)); k++) begin
        c = 8'($urandom);
        r.push_back(c);
      end
      pkt(r, crc_arc(r));
    end
    repeat (4) @(negedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/crc_stream_calculator.md
Name: crc_stream_calculator

Overview:
- Sequential, streaming successor of the single-step combinational CRC calculator.
- Accepts packets as a valid/ready word stream with start-of-packet, end-of-packet and empty-byte markers.
- Accumulates the CRC internally and presents the finished, post-processed CRC on a held valid/ready result port.
- Generalised in data width, CRC width, polynomial, init, reflection and final XOR. Sits between a packet source and a framer or checker.

Parameters:
- DATAWIDTH, 32, input word width in bits; multiple of 8, 8..128.
- CRCWIDTH, 16, CRC width in bits, 4..64.
- POLYNOMIAL, 16'h8005, generator polynomial, implicit top bit omitted.
- INIT, 16'h0000, register value loaded at start of packet.
- XOROUT, 16'h0000, value XORed into the final result.
- REFIN, 1, 1 = reflect bits within each input byte before processing.
- REFOUT, 1, 1 = reflect the whole CRC register before XOROUT.
- EMPTYWIDTH, $clog2(DATAWIDTH/8) (min 1), width of the empty field.
- CHECKVAL, 16'h0000, expected final value; used only with CRC_CHECK_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_dat  in  DATAWIDTH  data word; byte 0 = i_dat[DATAWIDTH-1 -: 8], processed first.
- i_val  in  1  input word valid.
- i_sop  in  1  word is first of packet; qualified by i_val.
- i_eop  in  1  word is last of packet; qualified by i_val.
- i_empty  in  EMPTYWIDTH  number of unused least-significant bytes in the eop word; ignored when i_eop=0.
- i_rdy  out  1  input ready.
- o_crc  out  CRCWIDTH  final CRC.
- o_val  out  1  result valid.
- o_rdy  in  1  result accepted.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; CRC register = INIT; o_val=0; o_crc=0; i_rdy=1 one cycle after release, combinationally per the rule below.
- Transfer rules:
  - Input transfer = i_val & i_rdy.
  - Output transfer = o_val & o_rdy.
  - i_rdy = (state != DONE) | o_rdy.
- IDLE:
  - Transfer with i_sop=1: register <= f(INIT, word). Go to BUSY, or DONE if i_eop=1.
  - Transfer without i_sop: word dropped, state unchanged.
- BUSY:
  - Transfer with i_sop=0: register <= f(reg, word). Go to DONE if i_eop=1.
  - Transfer with i_sop=1: packet restarts from INIT; previous partial CRC is discarded.
- DONE:
  - o_val=1.
  - o_crc = (REFOUT ? reflect(reg) : reg) ^ XOROUT, held stable until the output transfer.
  - Output transfer with no input transfer in the same cycle: go to IDLE.
  - Output transfer with a simultaneous sop input transfer: go to BUSY or DONE for the new packet. A new single-word packet yields o_val=1 with the new CRC on the next cycle, with no bubble.
  - Output transfer with a simultaneous non-sop input word: the word is dropped.
- Word processing f:
  - MSB-first, bytewise: byte 0 first, each byte reflected first if REFIN.
  - Equivalent to DATAWIDTH/8 chained 8-bit CRC steps.
  - On the eop word only the first DATAWIDTH/8 - i_empty bytes are processed. Implement as a mux over the per-byte-count chain taps.
  - i_empty >= DATAWIDTH/8 is treated as DATAWIDTH/8 - 1.
- Latency: result visible exactly 1 cycle after the eop word transfer. Throughput: 1 word/cycle.
- Reset asserted mid-packet or in DONE: o_val drops immediately; the pending result is lost.

Optional Feature:
- Macro: CRC_CHECK_EN.
- Defined:
  - Adds output o_ok, 1 bit, valid while o_val=1.
  - o_ok = (o_crc == CHECKVAL). Used to verify packets carrying an appended CRC.
  - Reset value 0.
- Undefined:
  - Port o_ok and the comparator are absent; CHECKVAL is ignored.

Test Plan:
- CRC-16/ARC defaults: "123456789" in three words (last word i_empty=3, sop on the first word, eop on the third) -> o_crc=16'hBB3D, one cycle after the eop transfer.
- REFIN=0, REFOUT=0, same stream -> o_crc=16'hFEE8. Then CRCWIDTH=32, POLYNOMIAL=32'h04C11DB7, INIT=XOROUT=32'hFFFFFFFF, reflections on -> o_crc=32'hCBF43926.
- Backpressure: hold o_rdy=0 for 5 cycles after the result -> o_crc stable, i_rdy=0, and a new packet waits. Raise o_rdy together with a new single-word sop+eop packet -> next result on the following cycle, no idle cycle.
- Resync: non-sop words in IDLE are ignored. A sop in BUSY restarts the packet, so a packet "xx" followed by sop "123456789" still gives 16'hBB3D. Reset pulsed mid-packet -> o_val=0 at once, and the next packet gives the correct CRC.
- CRC_CHECK_EN, CHECKVAL=0: "123456789" plus bytes 8'h3D, 8'hBB (11 bytes, i_empty=1) -> o_crc=16'h0000, o_ok=1. Corrupting any bit -> o_ok=0.
